// File: rtl/median_window_5x5_gen.sv
// median_window_5x5_gen
//   Streaming 5x5 neighbourhood generator for the median stage. Buffers the
//   four previous image rows and, for every 5x5 window lying fully inside the
//   image, presents the 25 window pixels with a one-cycle done_o strobe.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   pixel_i       incoming pixel, raster order
//   valid_i       pixel_i accepted this cycle (no backpressure)
//   S1..S25       window pixels, S1..S5 top row, S21..S25 newest row, S13 centre
//   done_o        S1..S25 hold a valid window this cycle
//   frame_done_o  coincident with the last done_o of a frame
module median_window_5x5_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pixel_i,
  input  logic                  valid_i,
  output logic [DATA_WIDTH-1:0] S1,  S2,  S3,  S4,  S5,
  output logic [DATA_WIDTH-1:0] S6,  S7,  S8,  S9,  S10,
  output logic [DATA_WIDTH-1:0] S11, S12, S13, S14, S15,
  output logic [DATA_WIDTH-1:0] S16, S17, S18, S19, S20,
  output logic [DATA_WIDTH-1:0] S21, S22, S23, S24, S25,
  output logic                  done_o,
  output logic                  frame_done_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(4);
  localparam logic [RW-1:0] ROW_MIN  = RW'(4);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // lb[0] holds row r-4, lb[3] holds row r-1 at the current column.
  logic [DATA_WIDTH-1:0] lb  [4][IMG_WIDTH];
  logic [DATA_WIDTH-1:0] win [5][5];

  logic col_wrap;
  logic row_wrap;

  always_comb begin
    col_wrap = (col == COL_LAST);
    row_wrap = (row == ROW_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (valid_i) begin
      if (col_wrap) begin
        col <= '0;
        row <= row_wrap ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Contents need no reset: windows drawn from stale rows are never flagged.
  always_ff @(posedge clk) begin
    if (valid_i && !rst) begin
      lb[0][col] <= lb[1][col];
      lb[1][col] <= lb[2][col];
      lb[2][col] <= lb[3][col];
      lb[3][col] <= pixel_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 5; i++)
        for (int unsigned j = 0; j < 5; j++)
          win[i][j] <= '0;
      done_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      done_o       <= valid_i && (row >= ROW_MIN) && (col >= COL_MIN);
      frame_done_o <= valid_i && row_wrap && col_wrap;
      if (valid_i) begin
        for (int unsigned i = 0; i < 5; i++)
          for (int unsigned j = 0; j < 4; j++)
            win[i][j] <= win[i][j+1];
        win[0][4] <= lb[0][col];
        win[1][4] <= lb[1][col];
        win[2][4] <= lb[2][col];
        win[3][4] <= lb[3][col];
        win[4][4] <= pixel_i;
      end
    end
  end

  assign S1  = win[0][0]; assign S2  = win[0][1]; assign S3  = win[0][2];
  assign S4  = win[0][3]; assign S5  = win[0][4];
  assign S6  = win[1][0]; assign S7  = win[1][1]; assign S8  = win[1][2];
  assign S9  = win[1][3]; assign S10 = win[1][4];
  assign S11 = win[2][0]; assign S12 = win[2][1]; assign S13 = win[2][2];
  assign S14 = win[2][3]; assign S15 = win[2][4];
  assign S16 = win[3][0]; assign S17 = win[3][1]; assign S18 = win[3][2];
  assign S19 = win[3][3]; assign S20 = win[3][4];
  assign S21 = win[4][0]; assign S22 = win[4][1]; assign S23 = win[4][2];
  assign S24 = win[4][3]; assign S25 = win[4][4];

endmodule

// File: doc/median_window_5x5_gen.md
Name: median_window_5x5_gen

Overview:
- Streaming 5x5 neighbourhood generator that feeds the 5x5 median calculation stage.
- Accepts a raster-order pixel stream, one pixel per cycle when valid_i is high, and buffers 4 previous image rows in line buffers.
- For every fully in-image 5x5 window, it presents 25 registered window pixels S1..S25 with a one-cycle done_o strobe.
- Sits between the pixel source (camera/DMA unpacker) and the median calculation pipeline. There is no backpressure; the downstream stage accepts one window per cycle.

Parameters:
- IMG_WIDTH, 640, pixels per row; legal range 5..4096.
- IMG_HEIGHT, 480, rows per frame; legal range 5..4096.
- DATA_WIDTH, 8, bits per pixel.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- pixel_i  input  DATA_WIDTH  incoming pixel, raster order (row-major, top-left first).
- valid_i  input  1  pixel_i is valid this cycle and is accepted unconditionally.
- S1 .. S25  output  DATA_WIDTH each  window pixels. S1..S5 = top row left→right; S21..S25 = bottom (newest) row left→right; S13 = window centre.
- done_o  output  1  one-cycle strobe; S1..S25 hold a valid window this cycle.
- frame_done_o  output  1  one-cycle strobe, coincident with the last done_o of a frame.

Behaviour:
- Reset:
  - S1..S25, done_o and frame_done_o are all 0.
  - Column and row counters are 0.
  - Line buffer contents are not cleared; they need no clearing (see suppression rule).
- Counters:
  - col increments on each accepted pixel, range 0..IMG_WIDTH-1.
  - At col = IMG_WIDTH-1, col wraps to 0 and row increments.
  - At row = IMG_HEIGHT-1 and col = IMG_WIDTH-1, both counters wrap to 0; the next accepted pixel starts a new frame.
- Line buffers:
  - 4 rows × IMG_WIDTH entries, addressed by col, with asynchronous read.
  - For an accepted pixel at (row r, col c), read LB0..LB3 at c, giving rows r-4..r-1.
  - Write-through shift at the same address: LB0←LB1, LB1←LB2, LB2←LB3, LB3←pixel_i.
- Window register:
  - On each accepted pixel, every window row shifts left by one column.
  - The new right column (S5, S10, S15, S20, S25) is loaded with (LB0, LB1, LB2, LB3, pixel_i) for pixel (r,c).
  - After the update, S25 = pixel(r,c) and S1 = pixel(r-4, c-4).
- Latency: done_o asserts exactly 1 cycle after the accepting edge of pixel (r,c), if and only if r ≥ 4 and c ≥ 4.
- Window count:
  - Output windows per frame = (IMG_WIDTH-4)·(IMG_HEIGHT-4).
  - There is no border padding; windows are valid-only.
  - The window centre is pixel (r-2, c-2).
- Suppression:
  - For c < 4 the window still holds pixels from the previous row's tail; done_o stays 0.
  - For r < 4 the line buffers hold the previous frame or garbage; done_o stays 0.
- Gaps: when valid_i = 0, nothing shifts, counters hold, and done_o = 0 the next cycle. S1..S25 hold their previous values and are don't-care while done_o = 0.
- frame_done_o asserts in the same cycle as the done_o produced by pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- Back-to-back frames: the first pixel of frame N+1 may be accepted on the cycle immediately after the last pixel of frame N, with no bubble required.
- Reset mid-frame:
  - Counters return to 0 and the outputs clear in the same edge.
  - The partially received frame is discarded.
  - The next accepted pixel is treated as (0,0).
- Counter widths: $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT). Compare against parameter-1 constants; no modular arithmetic.

Test Plan:
Bench uses IMG_WIDTH=8, IMG_HEIGHT=6, and pixel value = r·16 + c.
- Reset: hold rst 3 cycles with valid_i toggling → all S outputs = 0, done_o = 0, frame_done_o = 0 throughout.
- Continuous frame: stream 48 pixels with valid_i = 1 →
  - exactly 8 done_o pulses;
  - first pulse comes 1 cycle after pixel (4,4) is accepted, with S1 = 0x00, S13 = 0x22, S25 = 0x44;
  - last pulse has S1 = 0x13, S25 = 0x57, with frame_done_o = 1 in that same cycle.
- Gapped input: same frame, with valid_i low for 3 cycles after every pixel → same 8 windows with identical S values, each done_o 1 cycle after its pixel; no done_o during gaps.
- Row-edge suppression: pixel (5,3) accepted → done_o = 0 next cycle. Pixel (5,4) accepted → done_o = 1 with S1 = 0x10, S5 = 0x14, S21 = 0x50, S25 = 0x54.
- Back-to-back frames: frame 2 values = r·16 + c + 0x80, streamed with no gap →
  - frame 2 first window has S1 = 0x80, S25 = 0xC4, with no frame-1 data present;
  - 16 done_o pulses in total;
  - frame_done_o pulses exactly twice.
- Reset mid-frame: assert rst after 20 pixels, then stream a full frame → outputs are 0 during reset, followed by exactly 8 windows identical to the continuous-frame scenario.
